// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port: sweeps x1..x31 to INIT_VALUE after reset, then arbitrates
// core writeback (priority) against debug writes with a bounded-starvation override for debug.
module regfile_write_arbiter #(
    parameter logic [31:0] INIT_VALUE   = 32'h0000_0000,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_core_we,
    input  logic [4:0]  in_core_addr,
    input  logic [31:0] in_core_data,
    output logic        out_core_ready,
    input  logic        in_dbg_valid,
    input  logic [4:0]  in_dbg_addr,
    input  logic [31:0] in_dbg_data,
    output logic        out_dbg_ready,
    output logic        out_rf_write_enable,
    output logic [4:0]  out_rf_write_address,
    output logic [31:0] out_rf_write_data,
    output logic        out_init_done
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t      state, state_next;
    logic [4:0]  sweep_cnt;
    logic [3:0]  starve_cnt;
    logic        core_effective;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            sweep_cnt  <= 5'd1;
            starve_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                sweep_cnt <= sweep_cnt + 5'd1;
            end
            // A withdrawn request or a completed debug transfer restarts the starvation count
            if (in_dbg_valid && !out_dbg_ready) begin
                if (starve_cnt < STARVE_MAX) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

    assign core_effective = in_core_we && (in_core_addr != 5'd0);

    always_comb begin
        state_next           = state;
        out_core_ready       = 1'b0;
        out_dbg_ready        = 1'b0;
        out_init_done        = 1'b0;
        out_rf_write_enable  = 1'b0;
        out_rf_write_address = 5'd0;
        out_rf_write_data    = 32'd0;

        case (state)
            INIT: begin
                out_rf_write_enable  = 1'b1;
                out_rf_write_address = sweep_cnt;
                out_rf_write_data    = INIT_VALUE;
                if (sweep_cnt == 5'd31) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                out_init_done = 1'b1;
                if ((starve_cnt == STARVE_MAX) && in_dbg_valid) begin
                    out_dbg_ready = 1'b1;
                end else begin
                    out_core_ready = 1'b1;
                    out_dbg_ready  = in_dbg_valid && !core_effective;
                end

                // Writes to x0 are accepted but never reach the port
                if (out_dbg_ready) begin
                    if (in_dbg_addr != 5'd0) begin
                        out_rf_write_enable  = 1'b1;
                        out_rf_write_address = in_dbg_addr;
                        out_rf_write_data    = in_dbg_data;
                    end
                end else if (core_effective) begin
                    out_rf_write_enable  = 1'b1;
                    out_rf_write_address = in_core_addr;
                    out_rf_write_data    = in_core_data;
                end
            end

            default: begin
                state_next = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a vector table for RUN-mode arbitration plus
// hand-written sequences for the reset sweep and resets landing mid-sweep or mid-stall.
module tb_regfile_write_arbiter;

    localparam logic [31:0] INIT_VAL = 32'hDEAD_BEEF;
    localparam int          LIMIT    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_core_we;
    logic [4:0]  in_core_addr;
    logic [31:0] in_core_data;
    logic        out_core_ready;
    logic        in_dbg_valid;
    logic [4:0]  in_dbg_addr;
    logic [31:0] in_dbg_data;
    logic        out_dbg_ready;
    logic        out_rf_write_enable;
    logic [4:0]  out_rf_write_address;
    logic [31:0] out_rf_write_data;
    logic        out_init_done;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(
        .INIT_VALUE   (INIT_VAL),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_core_we           (in_core_we),
        .in_core_addr         (in_core_addr),
        .in_core_data         (in_core_data),
        .out_core_ready       (out_core_ready),
        .in_dbg_valid         (in_dbg_valid),
        .in_dbg_addr          (in_dbg_addr),
        .in_dbg_data          (in_dbg_data),
        .out_dbg_ready        (out_dbg_ready),
        .out_rf_write_enable  (out_rf_write_enable),
        .out_rf_write_address (out_rf_write_address),
        .out_rf_write_data    (out_rf_write_data),
        .out_init_done        (out_init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        core_we;
        logic [4:0]  core_addr;
        logic [31:0] core_data;
        logic        dbg_valid;
        logic [4:0]  dbg_addr;
        logic [31:0] dbg_data;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_core_ready;
        logic        exp_dbg_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic cwe, logic [4:0] ca, logic [31:0] cd,
                                logic dv, logic [4:0] da, logic [31:0] dd,
                                logic ewe, logic [4:0] ea, logic [31:0] ed,
                                logic ecr, logic edr);
        vec_t v;
        v.core_we = cwe;  v.core_addr = ca;  v.core_data = cd;
        v.dbg_valid = dv; v.dbg_addr = da;   v.dbg_data = dd;
        v.exp_we = ewe;   v.exp_addr = ea;   v.exp_data = ed;
        v.exp_core_ready = ecr;
        v.exp_dbg_ready  = edr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cwe, input logic [4:0] ca, input logic [31:0] cd,
                                 input logic dv, input logic [4:0] da, input logic [31:0] dd);
        in_core_we   = cwe;
        in_core_addr = ca;
        in_core_data = cd;
        in_dbg_valid = dv;
        in_dbg_addr  = da;
        in_dbg_data  = dd;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks INIT cycles first..31 (requests idle), then the first RUN cycle
    task automatic checkSweep(input string tag, input int first);
        for (int i = first; i <= 31; i++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            checkOutput({tag, "_we"},    32'(out_rf_write_enable), 32'd1);
            checkOutput({tag, "_addr"},  32'(out_rf_write_address), 32'(i));
            checkOutput({tag, "_data"},  out_rf_write_data, INIT_VAL);
            checkOutput({tag, "_done"},  32'(out_init_done), 32'd0);
            checkOutput({tag, "_cready"}, 32'(out_core_ready), 32'd0);
            checkOutput({tag, "_dready"}, 32'(out_dbg_ready), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput({tag, "_done_run"}, 32'(out_init_done), 32'd1);
        checkOutput({tag, "_we_run"},   32'(out_rf_write_enable), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Core x3 writes vs debug x9, then debug withdraw
        vecs.push_back(mk(1, 5'd5,  32'h1234, 0, 5'd0, 32'h0,  1, 5'd5,  32'h1234, 1, 0));
        vecs.push_back(mk(1, 5'd0,  32'h0099, 0, 5'd0, 32'h0,  0, 5'd0,  32'h0,    1, 0));
        vecs.push_back(mk(0, 5'd0,  32'h0,    1, 5'd7, 32'hAA, 1, 5'd7,  32'hAA,   1, 1));
        vecs.push_back(mk(0, 5'd0,  32'h0,    1, 5'd0, 32'h77, 0, 5'd0,  32'h0,    1, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 5'd3, 32'h33, 1, 5'd9, 32'h55, 1, 5'd3, 32'h33, 1, 0));
        vecs.push_back(mk(1, 5'd3,  32'h33,   1, 5'd9, 32'h55, 1, 5'd9,  32'h55,   0, 1));
        vecs.push_back(mk(1, 5'd3,  32'h33,   0, 5'd0, 32'h0,  1, 5'd3,  32'h33,   1, 0));
        vecs.push_back(mk(1, 5'd4,  32'h44,   1, 5'd10, 32'h66, 1, 5'd4, 32'h44,   1, 0));
        vecs.push_back(mk(1, 5'd4,  32'h44,   1, 5'd10, 32'h66, 1, 5'd4, 32'h44,   1, 0));
        vecs.push_back(mk(1, 5'd4,  32'h44,   0, 5'd10, 32'h66, 1, 5'd4, 32'h44,   1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 5'd4, 32'h44, 1, 5'd10, 32'h66, 1, 5'd4, 32'h44, 1, 0));
        vecs.push_back(mk(1, 5'd4,  32'h44,   1, 5'd10, 32'h66, 1, 5'd10, 32'h66,  0, 1));
        vecs.push_back(mk(1, 5'd4,  32'h44,   0, 5'd0, 32'h0,  1, 5'd4,  32'h44,   1, 0));
        vecs.push_back(mk(1, 5'd0,  32'h11,   1, 5'd12, 32'hC, 1, 5'd12, 32'hC,    1, 1));
        vecs.push_back(mk(1, 5'd31, 32'hFFFF_FFFF, 0, 5'd0, 32'h0, 1, 5'd31, 32'hFFFF_FFFF, 1, 0));

        // Reset sweep
        tick();
        tick();
        rst = 1'b0;
        checkSweep("sweep", 1);

        // RUN-mode vector table
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].core_we, vecs[i].core_addr, vecs[i].core_data,
                          vecs[i].dbg_valid, vecs[i].dbg_addr, vecs[i].dbg_data);
            checkOutput($sformatf("vec%0d_we", i),     32'(out_rf_write_enable), 32'(vecs[i].exp_we));
            checkOutput($sformatf("vec%0d_addr", i),   32'(out_rf_write_address), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("vec%0d_data", i),   out_rf_write_data, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_cready", i), 32'(out_core_ready), 32'(vecs[i].exp_core_ready));
            checkOutput($sformatf("vec%0d_dready", i), 32'(out_dbg_ready), 32'(vecs[i].exp_dbg_ready));
            tick();
        end

        // Reset during the 10th sweep cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("midsweep_addr10", 32'(out_rf_write_address), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkSweep("resweep", 1);
        tick();

        // Reset during a debug stall with the starve counter at 3
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h55);
            checkOutput($sformatf("stall%0d_dready", i), 32'(out_dbg_ready), 32'd0);
            checkOutput($sformatf("stall%0d_addr", i),   32'(out_rf_write_address), 32'd3);
            if (i == 3) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h55);
        checkOutput("rststall_dready", 32'(out_dbg_ready), 32'd0);
        checkOutput("rststall_cready", 32'(out_core_ready), 32'd0);
        checkOutput("rststall_addr",   32'(out_rf_write_address), 32'd1);
        checkOutput("rststall_data",   out_rf_write_data, INIT_VAL);
        tick();
        checkSweep("stallsweep", 2);
        tick();

        // Counter must have restarted from zero: four stalls before the override
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h55);
            checkOutput($sformatf("post%0d_dready", i), 32'(out_dbg_ready), (i == 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("post%0d_addr", i),   32'(out_rf_write_address), (i == 4) ? 32'd9 : 32'd3);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Owns the single write port of the register file and sequences all writes to it. After reset it sweeps x1..x31 to INIT_VALUE, because the register file has no reset of its own. It then shares the port between the core writeback path and a debug write requester, with core priority and a bounded-starvation override for debug. It sits between writeback/debug logic and the register file's write-enable, write-address and write-data inputs.

Parameters:
INIT_VALUE, 32'h0000_0000, value written to x1..x31 during the post-reset sweep
STARVE_LIMIT, 4, consecutive stalled debug cycles (1..15) after which debug preempts the core for one cycle

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_core_we  input  1  core writeback request
in_core_addr  input  5  core destination register
in_core_data  input  32  core writeback data
out_core_ready  output  1  core write accepted this cycle; core holds request while low
in_dbg_valid  input  1  debug write request
in_dbg_addr  input  5  debug destination register
in_dbg_data  input  32  debug write data
out_dbg_ready  output  1  debug write accepted this cycle
out_rf_write_enable  output  1  to register file write enable
out_rf_write_address  output  5  to register file write address
out_rf_write_data  output  32  to register file write data
out_init_done  output  1  high once the sweep completes

Behaviour:
- States: INIT, RUN. rst=1 at a clock edge -> INIT, sweep counter=1, starve counter=0. Reset takes priority over every other event, including mid-sweep and mid-stall; the sweep restarts at x1.
- Outputs are combinational from state, counters and inputs. The register file captures the write on the same rising edge.
- INIT:
  - out_rf_write_enable=1, address=sweep counter, data=INIT_VALUE.
  - Sweep counter increments each cycle. After the cycle that writes x31, next state is RUN.
  - INIT lasts exactly 31 cycles.
  - out_core_ready=0, out_dbg_ready=0, out_init_done=0.
- RUN:
  - out_init_done=1.
  - Core write is effective only when in_core_we=1 and in_core_addr!=0. A core write to x0 is accepted (out_core_ready=1) and dropped: it does not use the port.
  - Debug write to x0: accepted when granted, and the port shows write_enable=0.
  - Arbitration:
    - If starve counter==STARVE_LIMIT and in_dbg_valid=1: debug granted, out_dbg_ready=1, out_core_ready=0.
    - Else: out_core_ready=1. Debug is granted (out_dbg_ready=1) only if there is no effective core write.
    - The winner drives address/data. If there is no winner: enable=0, address=0, data=0.
  - Starve counter:
    - Increments (saturating at STARVE_LIMIT) on each cycle with in_dbg_valid=1 and out_dbg_ready=0.
    - Clears on a debug transfer or when in_dbg_valid=0.
- Handshake rules: a transfer occurs when request and ready are both high. Requesters hold address and data stable while stalled. A debug request may be withdrawn; the counter then clears.
- Simultaneous core and debug writes to the same address: only the granted one writes; the other lands in a later cycle.
- Never more than one write per cycle. Write enable is never asserted with address 0 in RUN.

Test Plan:
- Reset sweep: assert rst 2 cycles, release, INIT_VALUE=32'hDEAD_BEEF -> 31 consecutive writes to x1..x31 with data DEADBEEF. out_init_done rises on cycle 32. Both readys are 0 throughout.
- Core pass-through: in RUN, core we=1 addr=5 data=0x1234 -> same-cycle port write addr 5 data 0x1234, out_core_ready=1. Core addr=0 -> ready=1, write_enable=0.
- Debug on idle port: core we=0, dbg valid addr=7 data=0xAA -> port writes x7=0xAA, out_dbg_ready=1, starve counter stays 0.
- Starvation override: core writes x3 every cycle, dbg valid addr=9 data=0x55, STARVE_LIMIT=4 -> dbg stalled 4 cycles. On the 5th cycle x9=0x55 is written and out_core_ready=0. Core's x3 write lands the following cycle and the counter clears.
- Reset mid-operation: assert rst during the 10th sweep cycle and during a debug stall at counter=3 -> sweep restarts at x1 with the counter=0, no stale debug grant, 31 more INIT cycles.
- Debug withdraw: dbg valid for 2 stalled cycles, then low 1 cycle, then valid again with core busy -> override occurs only after 4 further stalled cycles.
